// File: rtl/axi_lite_initiator.sv
// AXI4-Lite initiator: turns single-beat local commands into one AXI4-Lite
// read or write at a time and returns data/response plus a saturating
// accept-to-handshake latency count. An optional watchdog flags stuck
// transactions without ever aborting them.
module axi_lite_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned LAT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    input  logic [2:0]           cmd_prot,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [LAT_WIDTH-1:0] rsp_cycles,
    output logic                 watchdog,
    output logic                 mem_axi_awvalid,
    input  logic                 mem_axi_awready,
    output logic [31:0]          mem_axi_awaddr,
    output logic [2:0]           mem_axi_awprot,
    output logic                 mem_axi_wvalid,
    input  logic                 mem_axi_wready,
    output logic [31:0]          mem_axi_wdata,
    output logic [3:0]           mem_axi_wstrb,
    input  logic                 mem_axi_bvalid,
    output logic                 mem_axi_bready,
    input  logic [1:0]           mem_axi_bresp,
    output logic                 mem_axi_arvalid,
    input  logic                 mem_axi_arready,
    output logic [31:0]          mem_axi_araddr,
    output logic [2:0]           mem_axi_arprot,
    input  logic                 mem_axi_rvalid,
    output logic                 mem_axi_rready,
    input  logic [31:0]          mem_axi_rdata,
    input  logic [1:0]           mem_axi_rresp
);

    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP, RSP} state_t;

    state_t      state;
    logic        aw_done, w_done;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  prot_q;
    logic        aw_hs, w_hs, busy, wd_hit;
    logic [31:0] cnt_inc;

    // Address/prot are latched once and shared by both address channels.
    assign mem_axi_awaddr = addr_q;
    assign mem_axi_araddr = addr_q;
    assign mem_axi_awprot = prot_q;
    assign mem_axi_arprot = prot_q;
    assign mem_axi_wdata  = wdata_q;
    assign mem_axi_wstrb  = wstrb_q;

    // Handshake decode and watchdog threshold test on the next count value.
    always_comb begin
        aw_hs   = mem_axi_awvalid && mem_axi_awready;
        w_hs    = mem_axi_wvalid && mem_axi_wready;
        busy    = (state == WREQ) || (state == WRESP) || (state == RREQ) || (state == RRESP);
        cnt_inc = 32'(rsp_cycles) + 32'd1;
        wd_hit  = (TIMEOUT_CYCLES != 0) && busy && (cnt_inc >= TIMEOUT_CYCLES);
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            cmd_ready       <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            prot_q          <= '0;
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= '0;
            rsp_cycles      <= '0;
            watchdog        <= 1'b0;
        end else begin
            // Counter runs only while waiting on the bus and sticks at all-ones.
            if (busy && (rsp_cycles != '1))
                rsp_cycles <= rsp_cycles + 1'b1;
            if (wd_hit)
                watchdog <= 1'b1;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        wstrb_q    <= cmd_wstrb;
                        prot_q     <= cmd_prot;
                        rsp_cycles <= '0;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        if (cmd_write) begin
                            mem_axi_awvalid <= 1'b1;
                            mem_axi_wvalid  <= 1'b1;
                            state           <= WREQ;
                        end else begin
                            mem_axi_arvalid <= 1'b1;
                            state           <= RREQ;
                        end
                    end
                end
                WREQ: begin
                    if (aw_hs) begin
                        mem_axi_awvalid <= 1'b0;
                        aw_done         <= 1'b1;
                    end
                    if (w_hs) begin
                        mem_axi_wvalid <= 1'b0;
                        w_done         <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        mem_axi_bready <= 1'b1;
                        state          <= WRESP;
                    end
                end
                WRESP: begin
                    if (mem_axi_bvalid && mem_axi_bready) begin
                        mem_axi_bready <= 1'b0;
                        rsp_resp       <= mem_axi_bresp;
                        rsp_rdata      <= '0;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RREQ: begin
                    if (mem_axi_arvalid && mem_axi_arready) begin
                        mem_axi_arvalid <= 1'b0;
                        mem_axi_rready  <= 1'b1;
                        state           <= RRESP;
                    end
                end
                RRESP: begin
                    if (mem_axi_rvalid && mem_axi_rready) begin
                        mem_axi_rready <= 1'b0;
                        rsp_rdata      <= mem_axi_rdata;
                        rsp_resp       <= mem_axi_rresp;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed bench: a configurable AXI4-Lite memory responder with per-channel
// ready/valid delays drives the initiator through reads, writes, early B,
// error responses, watchdog expiry and a mid-transaction reset.
module tb_axi_lite_initiator;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        cmd_ready, rsp_valid, watchdog;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] rsp_cycles;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi_lite_initiator #(.TIMEOUT_CYCLES(8), .LAT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles), .watchdog(watchdog),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp)
    );

    // Responder configuration, driven only by the stimulus block.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic        b_early = 1'b0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    // Responder state.
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        aw_have, w_have, rpend, bv;
    logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
    logic [3:0]  w_strb_q;
    logic [2:0]  cap_awprot, cap_arprot;
    logic [31:0] mem [16];
    logic        aw_hs, w_hs, have_a, have_w;
    logic [31:0] a_cur, d_cur;
    logic [3:0]  s_cur;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);
    assign rvalid  = rpend && (r_cnt >= r_dly);
    assign rdata   = rvalid ? mem[ar_addr_q[5:2]] : 32'h0;
    assign rresp   = rresp_cfg;
    assign bvalid  = bv;
    assign bresp   = bresp_cfg;

    always_comb begin
        aw_hs  = awvalid && awready;
        w_hs   = wvalid && wready;
        have_a = aw_have || aw_hs;
        have_w = w_have || w_hs;
        a_cur  = aw_hs ? awaddr : aw_addr_q;
        d_cur  = w_hs ? wdata : w_data_q;
        s_cur  = w_hs ? wstrb : w_strb_q;
    end

    // Memory responder: delayed readies, byte-strobed writes, delayed R.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_have <= 1'b0; w_have <= 1'b0; rpend <= 1'b0; bv <= 1'b0;
            aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0; ar_addr_q <= '0;
            cap_awprot <= '0; cap_arprot <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0101_0101 * i;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'hAABB_CCDD;
            mem[9] <= 32'hAABB_CCDD;
        end else begin
            if (aw_hs) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) w_cnt <= 0; else if (wvalid) w_cnt <= w_cnt + 1;
            if (arready) ar_cnt <= 0; else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (aw_hs) cap_awprot <= awprot;
            if (have_a && have_w) begin
                for (int b = 0; b < 4; b++)
                    if (s_cur[b]) mem[a_cur[5:2]][b*8 +: 8] <= d_cur[b*8 +: 8];
                aw_have <= 1'b0;
                w_have  <= 1'b0;
                bv      <= 1'b1;
            end else begin
                aw_have   <= have_a;
                w_have    <= have_w;
                aw_addr_q <= a_cur;
                w_data_q  <= d_cur;
                w_strb_q  <= s_cur;
            end
            if (b_early && awvalid && !awready && !aw_have && aw_cnt == 0) bv <= 1'b1;
            if (bv && bready) bv <= 1'b0;
            if (arready) begin
                ar_addr_q  <= araddr;
                cap_arprot <= arprot;
                rpend      <= 1'b1;
                r_cnt      <= 0;
            end
            if (rpend && !rvalid) r_cnt <= r_cnt + 1;
            if (rvalid && rready) begin
                rpend <= 1'b0;
                r_cnt <= 0;
            end
        end
    end

    // B-channel activity counters and first-watchdog snapshot.
    int          bready_cyc = 0, b_hs_cnt = 0;
    logic        wd_seen = 1'b0;
    logic [15:0] wd_at = '0;
    always @(posedge clk) begin
        if (bready) bready_cyc <= bready_cyc + 1;
        if (bready && bvalid) b_hs_cnt <= b_hs_cnt + 1;
    end
    always @(negedge clk) begin
        if (watchdog && !wd_seen) begin
            wd_seen <= 1'b1;
            wd_at   <= rsp_cycles;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr,
                          output logic [31:0] rd, output logic [1:0] rs,
                          output logic [15:0] cyc, output int lat);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wd; cmd_wstrb = st; cmd_prot = pr;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
        if (!cmd_ready) chk("cmd_ready_timeout", {31'b0, cmd_ready}, 32'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
        if (!rsp_valid) chk("rsp_valid_timeout", {31'b0, rsp_valid}, 32'h1);
        lat = n;
        rd  = rsp_rdata;
        rs  = rsp_resp;
        cyc = rsp_cycles;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [15:0] cyc;
    int          lat, br0, bh0;

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst_valids", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_watchdog", {31'b0, watchdog}, 32'h0);
        chk("rst_rsp_fields", {14'b0, rsp_cycles, rsp_resp}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1 resetn = 1'b1;

        // Zero-wait read
        do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'b101, rd, rs, cyc, lat);
        chk("rd0_data", rd, 32'hDEAD_BEEF);
        chk("rd0_resp", {30'b0, rs}, 32'h0);
        chk("rd0_cycles", {16'b0, cyc}, 32'd2);
        chk("rd0_turnaround", lat, 32'd3);
        chk("rd0_arprot", {29'b0, cap_arprot}, 32'h5);

        // Write, W accepted 3 cycles before AW
        aw_dly = 3; w_dly = 0; br0 = bready_cyc; bh0 = b_hs_cnt;
        do_cmd(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 3'b010, rd, rs, cyc, lat);
        chk("wrA_rdata", rd, 32'h0);
        chk("wrA_resp", {30'b0, rs}, 32'h0);
        chk("wrA_cycles", {16'b0, cyc}, 32'd5);
        chk("wrA_bready_cyc", bready_cyc - br0, 32'd1);
        chk("wrA_b_hs", b_hs_cnt - bh0, 32'd1);
        chk("wrA_mem", mem[8], 32'hAA22_CC44);
        chk("wrA_awprot", {29'b0, cap_awprot}, 32'h2);

        // Write, AW and W accepted in the same cycle
        aw_dly = 0; w_dly = 0; br0 = bready_cyc; bh0 = b_hs_cnt;
        do_cmd(1'b1, 32'h24, 32'h1122_3344, 4'b0101, 3'b000, rd, rs, cyc, lat);
        chk("wrB_rdata", rd, 32'h0);
        chk("wrB_cycles", {16'b0, cyc}, 32'd2);
        chk("wrB_bready_cyc", bready_cyc - br0, 32'd1);
        chk("wrB_mem", mem[9], 32'hAA22_CC44);

        // Early, held bvalid with an error BRESP
        aw_dly = 2; b_early = 1'b1; bresp_cfg = 2'b11; br0 = bready_cyc; bh0 = b_hs_cnt;
        do_cmd(1'b1, 32'h14, 32'hCAFE_F00D, 4'b1111, 3'b000, rd, rs, cyc, lat);
        chk("wrE_resp", {30'b0, rs}, 32'h3);
        chk("wrE_cycles", {16'b0, cyc}, 32'd4);
        chk("wrE_bready_cyc", bready_cyc - br0, 32'd1);
        chk("wrE_b_hs", b_hs_cnt - bh0, 32'd1);
        chk("wrE_mem", mem[5], 32'hCAFE_F00D);
        aw_dly = 0; b_early = 1'b0; bresp_cfg = 2'b00;

        // Delayed rvalid with SLVERR
        r_dly = 5; rresp_cfg = 2'b10;
        do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, rs, cyc, lat);
        chk("rdE_resp", {30'b0, rs}, 32'h2);
        chk("rdE_cycles", {16'b0, cyc}, 32'd7);
        chk("rdE_data", rd, 32'hDEAD_BEEF);
        chk("rdE_no_watchdog", {31'b0, watchdog}, 32'h0);
        r_dly = 0; rresp_cfg = 2'b00;

        // Watchdog: arready stalled 20 cycles
        ar_dly = 20;
        do_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, rs, cyc, lat);
        chk("wd_seen", {31'b0, wd_seen}, 32'h1);
        chk("wd_at_count", {16'b0, wd_at}, 32'd8);
        chk("wd_cycles", {16'b0, cyc}, 32'd22);
        chk("wd_data", rd, 32'h0303_0303);
        ar_dly = 0;
        do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, rs, cyc, lat);
        chk("wd_sticky", {31'b0, watchdog}, 32'h1);

        // Reset mid-WREQ
        aw_dly = 10; w_dly = 10;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h28;
        cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'hF;
        @(negedge clk);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_awvalid_before", {30'b0, awvalid, wvalid}, 32'h3);
        #2 resetn = 1'b0;
        #1;
        chk("mid_valids_dropped", {30'b0, awvalid, wvalid}, 32'h0);
        chk("mid_cmd_ready_low", {31'b0, cmd_ready}, 32'h0);
        chk("mid_watchdog_cleared", {31'b0, watchdog}, 32'h0);
        aw_dly = 0; w_dly = 0;
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("mid_cmd_ready_after", {31'b0, cmd_ready}, 32'h1);
        do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, rs, cyc, lat);
        chk("post_rst_data", rd, 32'hDEAD_BEEF);
        chk("post_rst_cycles", {16'b0, cyc}, 32'd2);
        chk("post_rst_mem_untouched", mem[10], 32'h0A0A_0A0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_initiator.md
Name: axi_lite_initiator

Overview:
Synthesizable AXI4-Lite initiator (master) for the simulation and FPGA test environment. It converts single-beat commands from a local valid/ready command port into AXI4-Lite read or write transactions, and returns the data and response on a local response port. It is the counterpart to the memory-responder side of the system bus. It drives DMA-style test traffic and debug accesses into any AXI4-Lite responder, including picorv32_axi peripheral slaves.

Parameters:
TIMEOUT_CYCLES, 0, watchdog limit in cycles from command accept to B/R handshake; 0 disables the watchdog.
LAT_WIDTH, 16, width of the rsp_cycles latency counter; the counter saturates at all-ones.

Ports:
clk  in  1  clock; all logic is on the rising edge.
resetn  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  32  byte address.
cmd_wdata  in  32  write data.
cmd_wstrb  in  4  write byte strobes.
cmd_prot  in  3  driven onto awprot/arprot.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_rdata  out  32  read data; 0 for writes.
rsp_resp  out  2  captured BRESP or RRESP.
rsp_cycles  out  LAT_WIDTH  cycles from command accept to B/R handshake, saturating.
watchdog  out  1  sticky flag; set when the watchdog expires.
mem_axi_awvalid/awready/awaddr[32]/awprot[3]  out/in/out/out  write address channel.
mem_axi_wvalid/wready/wdata[32]/wstrb[4]  out/in/out/out  write data channel.
mem_axi_bvalid/bready/bresp[2]  in/out/in  write response channel.
mem_axi_arvalid/arready/araddr[32]/arprot[3]  out/in/out/out  read address channel.
mem_axi_rvalid/rready/rdata[32]/rresp[2]  in/out/in  read data channel.

Behaviour:
- Reset (async, resetn=0) puts the FSM in IDLE.
  - All AXI valid/ready outputs, rsp_valid, watchdog, rsp_cycles, rsp_rdata and rsp_resp are 0.
  - cmd_ready = 0 while resetn = 0.
- Reset mid-transaction immediately drops every asserted valid/ready. There is no completion and no response.
- All AXI and response outputs are registered; there are no combinational in-to-out paths.
- cmd_ready = 1 only in IDLE, so at most one transaction is outstanding.
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP, RSP.
- IDLE: on command handshake, latch all command fields and clear the latency counter to 0.
  - Write: next state WREQ, with awvalid = wvalid = 1 from the following cycle.
  - Read: next state RREQ, with arvalid = 1 from the following cycle.
- WREQ: AW and W complete independently, tracked by aw_done and w_done flags.
  - awvalid deasserts on the cycle after awready is seen with awvalid high. wvalid follows the same rule with wready.
  - awaddr/wdata/wstrb/awprot stay stable while their valid is high.
  - When both flags are set (including the same cycle), next state is WRESP and bready = 1.
- WRESP: on bvalid && bready, capture bresp, set rsp_rdata = 0, drop bready, go to RSP.
  - bvalid arriving before WRESP is ignored because bready is low.
- RREQ: on arvalid && arready, drop arvalid, go to RRESP with rready = 1.
- RRESP: on rvalid && rready, capture rdata/rresp, drop rready, go to RSP.
- RSP: rsp_valid = 1 with stable fields. On rsp_ready, drop rsp_valid and return to IDLE; cmd_ready = 1 on the next cycle.
  - Minimum command-to-response-accept turnaround with a zero-wait responder: accept → valid (cycle 1) → handshake (1) → resp (2) → rsp_valid (3).
- Latency counter:
  - Increments every cycle from the cycle after accept up to and including the B/R handshake cycle.
  - Frozen in RSP; saturates at 2^LAT_WIDTH-1.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Sets when the counter reaches TIMEOUT_CYCLES while in WREQ/WRESP/RREQ/RRESP.
  - It never aborts the transaction (AXI forbids withdrawing valid), and the transaction still completes normally.
  - Cleared only by reset.
- Error responses (resp ≠ 0) are passed through unmodified; the block itself never errors.

Test Plan:
- Zero-wait responder; read 0x0000_0010 with memory word 0xDEADBEEF → rsp_rdata = 0xDEADBEEF, rsp_resp = 0, rsp_cycles = 2, arprot = cmd_prot.
- Write 0x0000_0020, data 0x11223344, wstrb 0b0101.
  - Variant A: responder accepts W 3 cycles before AW.
  - Variant B: responder accepts both in the same cycle.
  - Required: single bready window, memory updated only in bytes 0 and 2, rsp_rdata = 0.
- Responder asserts bvalid one cycle early (before awready) and holds it → no bready until both AW/W done; exactly one response.
- rresp = 2'b10, responder delays rvalid 5 cycles → rsp_resp = 2, rsp_cycles = 7.
- TIMEOUT_CYCLES = 8, responder stalls arready for 20 cycles → watchdog rises at count 8, transaction completes, watchdog stays 1 until reset.
- Reset asserted mid-WREQ → awvalid/wvalid drop asynchronously in the same cycle; after release cmd_ready = 1, and a fresh read completes correctly.
